// File: rtl/riscv_pkg.sv
// riscv_pkg: shared M-extension divide constants and divider FSM state type
package riscv_pkg;
  localparam logic [2:0] DIV_F3  = 3'b100;
  localparam logic [2:0] DIVU_F3 = 3'b101;
  localparam logic [2:0] REM_F3  = 3'b110;
  localparam logic [2:0] REMU_F3 = 3'b111;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_FIX} div_state_t;
endpackage

// File: rtl/riscv_div_step.sv
// riscv_div_step: one restoring-division iteration (rem,quot,dvs -> rem_n,quot_n) over XLEN+1 bits
module riscv_div_step #(parameter int XLEN = 32) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN:0]   dvs,
  output logic [XLEN:0]   rem_n,
  output logic [XLEN-1:0] quot_n
);
  logic [XLEN+1:0] sh;
  logic ge;
  always_comb begin
    sh = {rem, quot[XLEN-1]};
    ge = sh >= {1'b0, dvs};
    rem_n = (XLEN+1)'(ge ? sh - {1'b0, dvs} : sh);
    quot_n = {quot[XLEN-2:0], ge};
  end
endmodule

// File: rtl/riscv_div_ctrl.sv
// riscv_div_ctrl: iterative DIV/DIVU/REM/REMU(+W) divider; start_i/ready_o request in, done_o/result_o pulse out, kill_i flush
module riscv_div_ctrl import riscv_pkg::*; #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill_i,
  input  logic            start_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  div_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [XLEN:0] rem_q, rem_n, dvs_q, abs_b;
  logic [XLEN-1:0] quot_q, quot_n, abs_a;
  logic [XLEN-1:0] a_sx, a_ext, b_ext, min_w, spec_res, q_fix, r_fix, sel, fix_res;
  logic is_rem_q, word_q, neg_a_q, neg_b_q;
  logic word, sgn, neg_a, neg_b, dz, ovf, acc;
  riscv_div_step #(.XLEN(XLEN)) u_step (
    .rem(rem_q),
    .quot(quot_q),
    .dvs(dvs_q),
    .rem_n(rem_n),
    .quot_n(quot_n)
  );
  always_comb begin
    word = (XLEN == 64) && word_i;
    sgn = ~op_i[0];
    a_sx = XLEN'($signed(opa_i[31:0]));
    a_ext = word ? (sgn ? a_sx : XLEN'(opa_i[31:0])) : opa_i;
    b_ext = word ? (sgn ? XLEN'($signed(opb_i[31:0])) : XLEN'(opb_i[31:0])) : opb_i;
    neg_a = sgn & a_ext[XLEN-1];
    neg_b = sgn & b_ext[XLEN-1];
    abs_a = neg_a ? -a_ext : a_ext;
    abs_b = neg_b ? -{1'b1, b_ext} : {1'b0, b_ext};
    min_w = word ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    dz = b_ext == '0;
    ovf = sgn && a_ext == min_w && b_ext == '1;
    acc = start_i && state == DIV_IDLE && !kill_i && op_i[2];
    spec_res = dz ? (op_i[1] ? (word ? a_sx : opa_i) : '1) : (op_i[1] ? '0 : a_ext);
    q_fix = (neg_a_q ^ neg_b_q) ? -quot_q : quot_q;
    r_fix = neg_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    sel = is_rem_q ? r_fix : q_fix;
    fix_res = word_q ? XLEN'($signed(sel[31:0])) : sel;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = kill_i ? DIV_IDLE :
              state == DIV_IDLE ? ((acc && !dz && !ovf) ? DIV_BUSY : DIV_IDLE) :
              state == DIV_BUSY ? (cnt == '0 ? DIV_FIX : DIV_BUSY) : DIV_IDLE;
  end
  always_comb begin
    ready_o = state == DIV_IDLE;
    busy_o = state != DIV_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o <= 1'b0;
      result_o <= '0;
      cnt <= '0;
    end else begin
      done_o <= 1'b0;
      if (acc) begin
        is_rem_q <= op_i[1];
        word_q <= word;
        neg_a_q <= neg_a;
        neg_b_q <= neg_b;
        quot_q <= word ? abs_a << (XLEN - 32) : abs_a;
        dvs_q <= abs_b;
        rem_q <= '0;
        cnt <= word ? CW'(31) : CW'(XLEN - 1);
        if (dz || ovf) begin
          done_o <= 1'b1;
          result_o <= spec_res;
        end
      end else if (state == DIV_BUSY) begin
        rem_q <= rem_n;
        quot_q <= quot_n;
        cnt <= cnt - 1'b1;
      end else if (state == DIV_FIX && !kill_i) begin
        done_o <= 1'b1;
        result_o <= fix_res;
      end
    end
  end
endmodule

// File: tb/tb_riscv_div_ctrl.sv
// tb_riscv_div_ctrl: directed checks of riscv_div_ctrl at XLEN=32 and XLEN=64
module tb_riscv_div_ctrl;
  import riscv_pkg::*;
  logic clk = 1'b0;
  logic rst, kill, start, sel64, word;
  logic [2:0] op;
  logic [63:0] opa, opb;
  logic rdy32, busy32, done32, rdy64, busy64, done64;
  logic [31:0] res32;
  logic [63:0] res64;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  riscv_div_ctrl #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .kill_i(kill), .start_i(start & ~sel64), .ready_o(rdy32),
    .op_i(op), .word_i(word), .opa_i(opa[31:0]), .opb_i(opb[31:0]),
    .busy_o(busy32), .done_o(done32), .result_o(res32)
  );
  riscv_div_ctrl #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .kill_i(kill), .start_i(start & sel64), .ready_o(rdy64),
    .op_i(op), .word_i(word), .opa_i(opa), .opb_i(opb),
    .busy_o(busy64), .done_o(done64), .result_o(res64)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w64, input logic [2:0] o, input logic wd, input logic [63:0] a, input logic [63:0] b);
    sel64 = w64; op = o; word = wd; opa = a; opb = b; start = 1'b1;
    edge1();
    start = 1'b0;
  endtask
  task automatic go(input string tag, input logic w64, input logic [2:0] o, input logic wd,
                    input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp, input int lat);
    int n;
    issue(w64, o, wd, a, b);
    n = 1;
    while (!(w64 ? done64 : done32) && n < 100) begin
      edge1();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, w64 ? res64 : {32'h0, res32}, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; kill = 1'b0; start = 1'b1; sel64 = 1'b0; word = 1'b0;
    op = DIVU_F3; opa = 64'd100; opb = 64'd7;
    repeat (3) edge1();
    rst = 1'b0; start = 1'b0;
    chk("reset ready", {63'h0, rdy32}, 64'h1);
    chk("reset busy", {63'h0, busy32}, 64'h0);
    chk("reset done", {63'h0, done32}, 64'h0);
    chk("reset result", {32'h0, res32}, 64'h0);
    chk("reset result64", res64, 64'h0);
    edge1();
    go("divu 100/7", 1'b0, DIVU_F3, 1'b0, 64'd100, 64'd7, 64'd14, 34);
    go("remu 100/7", 1'b0, REMU_F3, 1'b0, 64'd100, 64'd7, 64'd2, 34);
    chk("done pulse width", {63'h0, done32}, 64'h1);
    edge1();
    chk("done one cycle", {63'h0, done32}, 64'h0);
    go("div -7/2", 1'b0, DIV_F3, 1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 34);
    go("rem -7/2", 1'b0, REM_F3, 1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 34);
    go("rem 7/-2", 1'b0, REM_F3, 1'b0, 64'd7, 64'hFFFF_FFFE, 64'd1, 34);
    go("div 0/9", 1'b0, DIV_F3, 1'b0, 64'd0, 64'd9, 64'd0, 34);
    go("divu 3/9", 1'b0, DIVU_F3, 1'b0, 64'd3, 64'd9, 64'd0, 34);
    go("divu big", 1'b0, DIVU_F3, 1'b0, 64'hFFFF_FFFF, 64'h8000_0000, 64'd1, 34);
    go("div 5/0", 1'b0, DIV_F3, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF, 1);
    chk("div0 stays idle", {63'h0, rdy32}, 64'h1);
    go("remu 5/0", 1'b0, REMU_F3, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    go("div ovf", 1'b0, DIV_F3, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1);
    go("rem ovf", 1'b0, REM_F3, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1);
    go("div min/1", 1'b0, DIV_F3, 1'b0, 64'h8000_0000, 64'd1, 64'h8000_0000, 34);
    go("divu word ignored", 1'b0, DIVU_F3, 1'b1, 64'd100, 64'd7, 64'd14, 34);
    edge1();
    issue(1'b0, DIVU_F3, 1'b0, 64'd9, 64'd3);
    repeat (9) edge1();
    chk("busy mid-op", {63'h0, busy32}, 64'h1);
    kill = 1'b1;
    edge1();
    kill = 1'b0;
    chk("kill ready", {63'h0, rdy32}, 64'h1);
    chk("kill no done", {63'h0, done32}, 64'h0);
    go("divu after kill", 1'b0, DIVU_F3, 1'b0, 64'd9, 64'd3, 64'd3, 34);
    edge1();
    issue(1'b0, DIVU_F3, 1'b0, 64'd100, 64'd7);
    repeat (32) edge1();
    kill = 1'b1;
    edge1();
    kill = 1'b0;
    chk("kill in fix done", {63'h0, done32}, 64'h0);
    chk("kill in fix result", {32'h0, res32}, 64'd3);
    chk("kill in fix ready", {63'h0, rdy32}, 64'h1);
    edge1();
    chk("kill in fix later", {63'h0, done32}, 64'h0);
    kill = 1'b1;
    issue(1'b0, DIVU_F3, 1'b0, 64'd9, 64'd3);
    kill = 1'b0;
    chk("kill beats start", {63'h0, busy32}, 64'h0);
    issue(1'b0, 3'b000, 1'b0, 64'd9, 64'd3);
    chk("op000 ready", {63'h0, rdy32}, 64'h1);
    edge1();
    chk("op000 no done", {63'h0, done32}, 64'h0);
    issue(1'b0, DIVU_F3, 1'b0, 64'd9, 64'd3);
    repeat (4) edge1();
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    chk("rst mid busy", {63'h0, busy32}, 64'h0);
    chk("rst mid done", {63'h0, done32}, 64'h0);
    chk("rst mid result", {32'h0, res32}, 64'h0);
    edge1();
    go("b2b first", 1'b0, DIVU_F3, 1'b0, 64'd100, 64'd7, 64'd14, 34);
    go("b2b second", 1'b0, DIVU_F3, 1'b0, 64'd50, 64'd5, 64'd10, 34);
    go("divw -7/2", 1'b1, DIV_F3, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    go("remw -7/2", 1'b1, REM_F3, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    go("divuw", 1'b1, DIVU_F3, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'h9999_9999_0000_0002, 64'h0000_0000_7FFF_FFFF, 34);
    go("remuw 0xffffffff/0", 1'b1, REMU_F3, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    go("divw ovf", 1'b1, DIV_F3, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    go("divu64", 1'b1, DIVU_F3, 1'b0, 64'h0000_0001_0000_0000, 64'd16, 64'h0000_0000_1000_0000, 66);
    go("rem64 -7/2", 1'b1, REM_F3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    go("div64 ovf", 1'b1, DIV_F3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_div_ctrl.md
Name: riscv_div_ctrl

Overview:
Iterative radix-2 restoring divider with its sequencing FSM, for the M-extension DIV/DIVU/REM/REMU and, when XLEN=64, DIVW/DIVUW/REMW/REMUW.
Sits beside the execution-stage ALU; the execution stage issues one request through a ready/start handshake and receives one registered result pulse.
Handles the RISC-V divide-by-zero and signed-overflow cases in a single cycle, without iterating.
Supports pipeline flush via kill_i.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
kill_i  in  1  flush; aborts any operation in progress
start_i  in  1  request valid
ready_o  out  1  block can accept a request
op_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
word_i  in  1  W-variant; ignored when XLEN=32
opa_i  in  XLEN  dividend (rs1)
opb_i  in  XLEN  divisor (rs2)
busy_o  out  1  operation in progress
done_o  out  1  one-cycle result-valid pulse
result_o  out  XLEN  quotient or remainder; held until next done_o

Behaviour:
- Reset and port protocol:
  - One clock (clk); reset is synchronous and active-high (rst).
  - At the first clk edge with rst high: state=IDLE, done_o=0, result_o=0, counter=0. start_i is ignored while rst is high.
  - ready_o = (state==IDLE); busy_o = (state!=IDLE). Both are combinational from state.
  - Accept occurs on a cycle with start_i & ready_o & ~kill_i & op_i[2]. Requests with op_i[2]==0 are ignored: no accept, no done_o.
- States: IDLE, BUSY, FIX.
- Accept edge (cycle t):
  - Latch op, word, and the signs of the dividend and divisor. Signed only for DIV/REM.
  - Load |a| and |b|, with |x| taken in XLEN+1 bits so that the most-negative value is exact.
  - Word mode: operands are first sign-extended (signed op) or zero-extended (unsigned op) from bits [31:0]. Iteration count N=32; otherwise N=XLEN.
  - Divisor==0: done_o=1 at t+1; result = all-ones (DIV/DIVU) or the dividend (REM/REMU). State stays IDLE.
  - Signed overflow (dividend = -2^(W-1), divisor = -1, W = 32 in word mode): result = dividend (DIV) or 0 (REM); done_o at t+1.
  - Otherwise: state=BUSY, counter=N-1, remainder register=0.
- BUSY (one iteration per cycle, N cycles):
  - rem' = {rem, quot[msb]}; quot shifts left.
  - If rem' >= |b|: rem' -= |b| and the new quotient lsb = 1.
  - counter==0 -> FIX; otherwise counter decrements.
- FIX (one cycle):
  - Negate the quotient if the operand signs differ (signed op).
  - Negate the remainder if the dividend is negative (signed op).
  - Select quotient or remainder per op.
  - Word mode: sign-extend bit 31 to XLEN.
  - Edge: result_o updated, done_o=1, state=IDLE.
- Latency from accept to done_o: N+2 cycles (34 for XLEN=32 and for word ops).
- done_o is high for exactly one cycle. A new request may be accepted in the done_o cycle (back-to-back).
- kill_i high in any cycle:
  - Next state is IDLE and no done_o follows for the killed operation.
  - kill_i in the FIX cycle suppresses done_o.
  - kill_i together with start_i: kill wins and nothing is accepted.
  - result_o keeps its last value.
- Dividend 0 and |a| < |b| are not special cases; they take the normal path.

Decomposition:
- riscv_pkg gains:
  - funct3 constants DIV_F3=3'b100, DIVU_F3=3'b101, REM_F3=3'b110, REMU_F3=3'b111;
  - typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_FIX} div_state_t.
- One natural sub-module: riscv_div_step. It is the combinational single-iteration shift/compare/subtract over XLEN+1 bits, instantiated once by riscv_div_ctrl. The FSM, counter, special-case detection and sign fix stay in riscv_div_ctrl.

Test Plan:
- DIVU 100/7 accepted at t -> done_o only at t+34, result 14; REMU same operands -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/-2 -> 1 (sign follows dividend).
- DIV 5/0 -> 0xFFFFFFFF at t+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at t+1, REM -> 0.
- DIVU 9/3 with kill_i at t+10 -> no done_o, ready_o=1 at t+11; new DIVU 9/3 accepted at t+11 -> 3 at t+45; rst at t+5 of another op -> IDLE next cycle, done_o=0, result_o=0.
- Back-to-back: second start_i during the done_o cycle is accepted; its done_o arrives 34 cycles later; start_i with op_i=000 -> ignored, ready_o stays 1.
- XLEN=64, DIVW opa=0x00000000_FFFFFFF9, opb=2 -> 0xFFFFFFFF_FFFFFFFD at t+34; REMUW 0xFFFFFFFF/0 -> 0xFFFFFFFF_FFFFFFFF.
